// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for reg_write_arbiter and its round-robin picker.
package reg_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam int HOLD_W = 4;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin winner select: first set req bit at or after ptr, wrapping.
module rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [idx_w(N)-1:0]   winner,
  output logic                  valid
);
  localparam int IW = idx_w(N);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!valid && req[(int'(ptr) + off) % N]) begin
        valid  = 1'b1;
        winner = IW'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit register, with bounded lock bursts.
// Optional: define REG_WRITE_ARBITER_PRIO0_EN to give requester 0 fixed high priority.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          lock,
  input  logic [N*WIDTH-1:0]    wdata,
  output logic [N-1:0]          gnt,
  output logic [WIDTH-1:0]      q,
  output logic [idx_w(N)-1:0]   owner,
  output logic                  busy
);
  localparam int IW = idx_w(N);

  logic [N-1:0][WIDTH-1:0] wd;
  assign wd = wdata;

  state_e            state, state_n;
  logic [IW-1:0]     ptr, ptr_n, owner_n, win, win_nxt;
  logic              win_vld;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [N-1:0]      gnt_n;
  logic [WIDTH-1:0]  q_n;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_vld)
  );

  assign win_nxt = (win == IW'(N - 1)) ? '0 : win + IW'(1);
  assign busy    = (state == OWNED);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    gnt_n   = gnt;
    q_n     = q;
    case (state)
      IDLE: begin
        gnt_n = '0;
`ifdef REG_WRITE_ARBITER_PRIO0_EN
        if (req[0]) begin
          // Override win leaves the rotation untouched.
          gnt_n   = N'(1);
          q_n     = wd[0];
          owner_n = '0;
          if (lock[0]) begin
            state_n = OWNED;
            cnt_n   = HOLD_W'(1);
          end
        end else
`endif
        if (win_vld) begin
          gnt_n   = N'(1) << win;
          q_n     = wd[win];
          owner_n = win;
          ptr_n   = win_nxt;
          if (lock[win]) begin
            state_n = OWNED;
            cnt_n   = HOLD_W'(1);
          end
        end
      end
      OWNED: begin
`ifdef REG_WRITE_ARBITER_PRIO0_EN
        if (req[0] && (owner != '0)) begin
          gnt_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else
`endif
        if (req[owner]) begin
          q_n = wd[owner];
          if (lock[owner] && (cnt < HOLD_W'(MAX_HOLD))) begin
            cnt_n = cnt + HOLD_W'(1);
          end else begin
            gnt_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          gnt_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        gnt_n   = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      gnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      q     <= q_n;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (N=4, WIDTH=8, MAX_HOLD=4).
module tb_reg_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, lock;
  logic [3:0][7:0] wd;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  int total = 0;
  int bad   = 0;

  assign wdata = wd;

  reg_write_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; wd = '0;
    step(); step();
    chk("rst_gnt", gnt, 0); chk("rst_q", q, 0);
    chk("rst_busy", busy, 0); chk("rst_owner", owner, 0);
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_gnt", gnt, 0); chk("idle_q", q, 0); chk("idle_busy", busy, 0);
    end

    // Round-robin over all four requesters
    wd[0] = 8'h10; wd[1] = 8'h11; wd[2] = 8'h12; wd[3] = 8'h13;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] eg;
      logic [7:0] eq;
      eg = 4'b0001 << (k % 4);
      eq = 8'h10 + 8'(k % 4);
      step();
      chk("rr_gnt", gnt, eg); chk("rr_q", q, eq); chk("rr_busy", busy, 0);
    end

    // Grant 1 so ptr moves to 2
    req = 4'b0010;
    step();
    chk("pre_gnt", gnt, 4'b0010); chk("pre_q", q, 8'h11);

    // Locked burst by 2 with 1 waiting
    req = 4'b0110; lock = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      wd[2] = 8'hA0 + 8'(k);
      step();
      chk("burst_gnt", gnt, 4'b0100); chk("burst_q", q, 8'hA0 + 32'(k));
      chk("burst_busy", busy, 1); chk("burst_owner", owner, 2);
    end
    wd[2] = 8'hA4;
    step();
    chk("burst_end_gnt", gnt, 0); chk("burst_end_busy", busy, 0); chk("burst_end_q", q, 8'hA4);
    step();
    chk("wrap_gnt", gnt, 4'b0010); chk("wrap_q", q, 8'h11); chk("wrap_owner", owner, 1);
    req = '0; lock = '0;
    step();
    chk("gap_gnt", gnt, 0);

    // Mid-burst reset
    req = 4'b1000; lock = 4'b1000; wd[3] = 8'h33;
    step();
    chk("mr_gnt", gnt, 4'b1000); chk("mr_busy", busy, 1); chk("mr_q", q, 8'h33);
    reset = 1'b1;
    step();
    chk("mr_rst_gnt", gnt, 0); chk("mr_rst_q", q, 0);
    chk("mr_rst_busy", busy, 0); chk("mr_rst_owner", owner, 0);
    reset = 1'b0; lock = '0;
    step();
    chk("mr_regrant_gnt", gnt, 4'b1000); chk("mr_regrant_q", q, 8'h33);
    chk("mr_regrant_owner", owner, 3);
    req = '0;
    step();

    // Owner drops req mid-burst; req[3] must be ignored while owned
    req = 4'b1010; lock = 4'b0010; wd[1] = 8'h55; wd[3] = 8'h77;
    step();
    chk("drop_gnt0", gnt, 4'b0010); chk("drop_q0", q, 8'h55); chk("drop_busy0", busy, 1);
    wd[1] = 8'h56;
    step();
    chk("drop_gnt1", gnt, 4'b0010); chk("drop_q1", q, 8'h56);
    req = 4'b1000; wd[1] = 8'h57;
    step();
    chk("drop_gnt2", gnt, 0); chk("drop_q2", q, 8'h56); chk("drop_busy2", busy, 0);
    step();
    chk("drop_next_gnt", gnt, 4'b1000); chk("drop_next_q", q, 8'h77);
    req = '0; lock = '0;
    step();

    // Owner 2 locked, then req[0] arrives
    req = 4'b0100; lock = 4'b0100; wd[2] = 8'hC0; wd[0] = 8'h0F;
    step();
    chk("p0_gnt", gnt, 4'b0100); chk("p0_q", q, 8'hC0);
    req = 4'b0101; wd[2] = 8'hC1;
`ifdef REG_WRITE_ARBITER_PRIO0_EN
    lock = 4'b0000;
    step();
    chk("p0_rel_gnt", gnt, 0); chk("p0_rel_q", q, 8'hC0); chk("p0_rel_busy", busy, 0);
    step();
    chk("p0_win_gnt", gnt, 4'b0001); chk("p0_win_q", q, 8'h0F);
    req = 4'b1010;
    step();
    chk("p0_ptr_gnt", gnt, 4'b1000);
`else
    step();
    chk("p0_keep_gnt", gnt, 4'b0100); chk("p0_keep_q", q, 8'hC1); chk("p0_keep_busy", busy, 1);
    lock = 4'b0000; wd[2] = 8'hC2;
    step();
    chk("p0_final_gnt", gnt, 0); chk("p0_final_q", q, 8'hC2);
    step();
    chk("p0_next_gnt", gnt, 4'b0001); chk("p0_next_q", q, 8'h0F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit register (a bank of synchronous-reset D flip-flops) between N requesters.
- Round-robin arbitration grants one write per cycle.
- A requester may lock the register for a bounded multi-cycle burst.
- Sits in front of any shared state register in the Flipflops/sequential designs.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register.
- MAX_HOLD, 4, maximum consecutive cycles a locked owner may keep the grant (1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester write request.
- lock  input  N  per-requester request to keep ownership after the grant.
- wdata  input  N*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N  registered one-hot grant; all zero when idle.
- q  output  WIDTH  shared register contents.
- owner  output  clog2(N)  index of the last granted requester.
- busy  output  1  high while in OWNED state.

Behaviour:
- Reset (synchronous, sampled at posedge clk with reset=1):
  - gnt=0, q=0, owner=0, busy=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset overrides everything, including mid-burst; there is no partial write on the reset edge.
- States: IDLE, OWNED.
- IDLE, req != 0 at an edge:
  - Winner w = first i with req[i]=1, searching ptr, ptr+1, ... with wrap mod N.
  - Registered updates: gnt<=onehot(w), q<=wdata[w], owner<=w, ptr<=(w+1) mod N.
  - If lock[w]=1: state<=OWNED, busy<=1, hold counter<=1.
  - Otherwise stay IDLE; gnt is a one-cycle pulse and arbitration reruns next edge.
- IDLE, req == 0: gnt<=0; q, owner, ptr hold.
- OWNED: only requester owner is considered; all other req bits are ignored (no grant, no write).
  - req[owner]=1 and lock[owner]=1 and counter<MAX_HOLD: q<=wdata[owner], gnt holds, counter++.
  - req[owner]=1 and (lock[owner]=0 or counter==MAX_HOLD): final write q<=wdata[owner]; then gnt<=0, busy<=0, counter<=0, state<=IDLE.
  - req[owner]=0: no write; gnt<=0, busy<=0, state<=IDLE.
- After release, the next arbitration starts no earlier than the following edge; ptr already points past the owner.
- Latency: request sampled at edge k; gnt and new q are both visible after edge k. q changes only on a granted write.
- Wrap: if ptr=N-1 and only req[0] is high, 0 wins and ptr becomes 1.
- Simultaneous requests: exactly one winner per edge; gnt is never multi-hot.
- MAX_HOLD=1: a lock yields exactly one write in OWNED after the grant write (two writes total).

Optional Feature:
- Macro: REG_WRITE_ARBITER_PRIO0_EN.
- Defined: requester 0 is fixed high priority.
  - In IDLE, req[0] wins regardless of ptr; ptr is not updated when 0 wins via override.
  - In OWNED by another requester, req[0]=1 forces release at the next edge, with no write by the owner on that edge; req[0] is then arbitrated on the following edge.
- Undefined: pure round-robin as above. Requester 0 has no special rights.

Decomposition:
- Shared package holds:
  - state enum (IDLE=1'b0, OWNED=1'b1);
  - IDX_W=$clog2(N) helper;
  - hold counter width constant (4 bits).
- One natural sub-module: rr_pick, a combinational round-robin winner select (req, ptr -> winner index, valid).
- The register itself stays inline.

Test Plan:
All cases use N=4, WIDTH=8, MAX_HOLD=4.
- Reset then req=4'b0000 for 3 cycles -> gnt=0, q=8'h00, busy=0 throughout.
- req=4'b1111, lock=0, wdata[i]=8'h10+i, held 5 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001; q = 10, 11, 12, 13, 10.
- req[2]=1, lock[2]=1, wdata[2] incrementing from 8'hA0, req[1]=1 constantly:
  - gnt=0100 for exactly 4 cycles, q=A0..A3, busy high for those cycles;
  - then gnt=0 for one cycle;
  - then gnt=0010 (ptr=3 wraps to 1).
- Mid-burst reset: lock owner 3, assert reset for 1 cycle during cycle 2 -> next cycle gnt=0, q=00, busy=0, ptr=0; req[3] is re-arbitrated fresh.
- Owner drops req during a burst: owner 1 locked, req[1]=0 at cycle 2 -> no write on that edge, q holds its cycle-1 value, gnt=0, state IDLE.
- With REG_WRITE_ARBITER_PRIO0_EN: owner 2 locked, req[0] asserted -> gnt=0 on the next edge, then gnt=0001 and q=wdata[0]; ptr unchanged.
